// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// a registered fill level, optional first-word-fall-through read mode and
// sticky overflow / underflow error flags.
module sync_fifo_prog #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 16,
    parameter bit  FWFT       = 1'b0,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int AW = CW - 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          rd_ok;
    logic          wr_ok;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Pointers carry a wrap bit; only the low bits address the memory.
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Flags come straight from the count register, so threshold changes act at once.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept/reject decision; a read frees a slot, so a write to a full FIFO
    // alongside an accepted read still goes through.
    always_comb begin
        rd_ok = rd_en && !empty;
        wr_ok = wr_en && (!full || rd_ok);
    end

    // Next pointer, fill level and sticky error state.
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + CW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event in the same cycle as clr_err keeps the flag set.
        if (wr_en && !wr_ok) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en && !rd_ok) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; never reset, stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_idx] <= din;
        end
    end

    generate
        if (!FWFT) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            // Registered read port: load the head word on an accepted read, else hold.
            always_comb begin
                dout_d = rd_ok ? mem_q[rd_idx] : dout_q;
            end

            // Output data register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign dout = dout_q;
        end else begin : g_fwft
            // Head word falls through whenever something is stored; zero while empty.
            always_comb begin
                dout = empty ? '0 : mem_q[rd_idx];
            end
        end
    endgenerate

    // Pointer distance (with wrap bit) must always equal the fill level.
    a_ptr_count : assert property (@(posedge clk) disable iff (rst)
        (CW'(wr_ptr_q - rd_ptr_q) == count_q));

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: one standard-mode and one FWFT instance
// driven by the same stimulus, checked against a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, clr_err;
    logic [DW-1:0] din;
    logic [CW-1:0] af_thresh, ae_thresh;

    logic [DW-1:0] dout_0, dout_1;
    logic          full_0, empty_0, af_0, ae_0, ovf_0, unf_0;
    logic          full_1, empty_1, af_1, ae_1, ovf_1, unf_1;
    logic [CW-1:0] count_0, count_1;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_0),
        .full(full_0), .empty(empty_0), .almost_full(af_0), .almost_empty(ae_0),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count_0),
        .overflow(ovf_0), .underflow(unf_0), .clr_err(clr_err)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_1),
        .full(full_1), .empty(empty_1), .almost_full(af_1), .almost_empty(ae_1),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count_1),
        .overflow(ovf_1), .underflow(unf_1), .clr_err(clr_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a plain queue plus sticky error bits.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_unf;
    bit            fire0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] last_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        logic [DW-1:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        chk("count0", 32'(count_0), 32'(n));
        chk("full0",  32'(full_0),  32'(n == DEPTH));
        chk("empty0", 32'(empty_0), 32'(n == 0));
        chk("af0",    32'(af_0),    32'(n >= int'(af_thresh)));
        chk("ae0",    32'(ae_0),    32'(n <= int'(ae_thresh)));
        chk("ovf0",   32'(ovf_0),   32'(m_ovf));
        chk("unf0",   32'(unf_0),   32'(m_unf));
        chk("status1", 32'({count_1, full_1, empty_1, af_1, ae_1, ovf_1, unf_1}),
            32'({CW'(n), n == DEPTH, n == 0, n >= int'(af_thresh), n <= int'(ae_thresh),
                 m_ovf, m_unf}));
        chk("dout1", 32'(dout_1), 32'(head));
    endtask

    // One clock of stimulus: model decides acceptance from the rules, DUT state
    // is compared after the edge; read data goes to the scoreboard.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit r_ok, w_ok;
        @(negedge clk);
        wr_en   = wr;
        din     = d;
        rd_en   = rd;
        clr_err = clr;
        r_ok = rd && (model_q.size() > 0);
        w_ok = wr && ((model_q.size() < DEPTH) || r_ok);
        fire0 = r_ok;
        if (r_ok) exp_q.push_back(model_q.pop_front());
        if (w_ok) model_q.push_back(d);
        if (wr && !w_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (rd && !r_ok) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = 1'b1;
        din     = 8'h77;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        fire0   = 1'b0;
        last_out = '0;
        exp_q.delete();
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check_state();
        chk("rst_dout0", 32'(dout_0), 32'h0);
    endtask

    // Monitor: after each edge, a read accepted on that edge must present the
    // next scoreboard entry on the standard-mode output; otherwise dout holds.
    initial begin
        bit f;
        forever begin
            @(posedge clk);
            f = fire0;
            #1;
            if (mon_en) begin
                if (f) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_empty: read fired with no expected word at %0t", $time);
                    end else begin
                        last_out = exp_q.pop_front();
                    end
                end
                chk("dout0", 32'(dout_0), 32'(last_out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        af_thresh = 5'd14; ae_thresh = 5'd2;
        fire0 = 1'b0; last_out = '0;

        // Reset held 2 clocks with a write pending.
        do_reset(2);
        mon_en = 1'b1;

        // Fill 0x00..0x0F, almost_full rises on the 14th write, 17th overflows.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 12) chk("af_before14", 32'(af_0), 32'h0);
            if (i == 13) chk("af_at14", 32'(af_0), 32'h1);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_17th", 32'(ovf_0), 32'h1);
        chk("count_17th", 32'(count_0), 32'd16);

        // Drain: scoreboard checks 0x00..0x0F, 17th read underflows and dout holds.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_17th", 32'(unf_0), 32'h1);
        chk("dout_hold", 32'(dout_0), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous read+write of 0xAA; 0xAA must come out 16th.
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw_count", 32'(count_0), 32'd16);
        chk("full_rw_ovf", 32'(ovf_0), 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("aa_16th", 32'(dout_0), 32'hAA);
        // Empty with both: write accepted, read rejected.
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("empty_rw_count", 32'(count_0), 32'd1);
        chk("empty_rw_unf", 32'(unf_0), 32'h1);
        // Clear coinciding with a new error event: the set wins.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("set_beats_clr", 32'(unf_0), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random interleaved traffic across many pointer wraps.
        for (int i = 0; i < 300; i++) begin
            if (i >= 150 && (i % 10) == 0) begin
                af_thresh = 5'($urandom_range(0, 16));
                ae_thresh = 5'($urandom_range(0, 16));
            end
            step($urandom_range(0, 99) < 55, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 15) == 0);
        end
        af_thresh = 5'd14;
        ae_thresh = 5'd2;

        // Reset mid-operation discards stored data.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        do_reset(1);
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_data", 32'(dout_0), 32'h21);

        // FWFT: head word visible the clock after the filling write.
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("fwft_head", 32'(dout_1), 32'h5C);
        chk("fwft_nonempty", 32'(empty_1), 32'h0);
        chk("ae_at_thr2", 32'(ae_1), 32'h1);
        // Threshold change acts combinationally, no clock edge needed.
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; fire0 = 1'b0;
        ae_thresh = 5'd0;
        #1;
        chk("ae_thr0_same_cycle0", 32'(ae_0), 32'h0);
        chk("ae_thr0_same_cycle1", 32'(ae_1), 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_empty", 32'(empty_1), 32'h1);
        chk("fwft_zero", 32'(dout_1), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
